// File: rtl/ahb_slave_if_if.sv
// AHB-Lite slave bus bundle: AHB address/data phase inputs plus the pipelined
// request that the bridge front end hands to the APB controller.
interface ahb_slave_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              Hwrite;
    logic              Hreadyin;
    logic [1:0]        Htrans;
    logic [2:0]        Hsize;
    logic [2:0]        Hburst;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              apb_ready;

    logic              valid;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata1;
    logic [DATA_W-1:0] Hwdata2;
    logic              Hwritereg;
    logic              Hwritereg1;
    logic [2:0]        tempselx;
    logic              Hreadyout;
    logic [1:0]        Hresp;
    logic              burst_err;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Hsize, Hburst, Haddr, Hwdata, apb_ready,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
               tempselx, Hreadyout, Hresp, burst_err
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Hsize, Hburst, Haddr, Hwdata, apb_ready,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
               tempselx, Hreadyout, Hresp, burst_err
    );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: address/data pipeline,
// peripheral decode, two-cycle ERROR response and burst sequence checking.
module ahb_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           Hclk,
    input  logic           Hreset,
    ahb_slave_if_if.slave  bus
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_OKAY = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } resp_state_e;

    resp_state_e r_state, w_state_nxt;

    logic              w_hreadyout;
    logic [1:0]        w_hresp;
    logic              w_xfer;
    logic              w_accept;
    logic              w_ok;
    logic [2:0]        w_sel;

    logic              r_valid;
    logic              r_dphase;
    logic [ADDR_W-1:0] r_haddr1, r_haddr2;
    logic [DATA_W-1:0] r_hwdata1, r_hwdata2;
    logic              r_hwrite1, r_hwrite2;
    logic [2:0]        r_sel;

    logic              r_in_burst;
    logic              r_fixed;
    logic              r_wrap;
    logic [4:0]        r_beats_left;
    logic [ADDR_W-1:0] r_exp_addr;
    logic [ADDR_W-1:0] r_incr;
    logic [ADDR_W-1:0] r_mask;
    logic              r_burst_err;

    logic [4:0]        w_beats_m1;
    logic [5:0]        w_len;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_mask;
    logic              w_is_wrap;
    logic              w_seq_err;

    // Only the low, boundary-aligned bits wrap; upper address bits are held.
    function automatic logic [ADDR_W-1:0] f_next(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] incr,
        input logic [ADDR_W-1:0] mask,
        input logic              wrap
    );
        logic [ADDR_W-1:0] s;
        s = a + incr;
        return wrap ? ((a & ~mask) | (s & mask)) : s;
    endfunction

    // Hreadyout in OKAY equals apb_ready, so the transfer qualifier avoids a comb loop.
    assign w_xfer   = (r_state == S_OKAY) && bus.Hreadyin && bus.apb_ready;
    assign w_accept = w_xfer && bus.Htrans[1];
    assign w_ok     = (w_sel != 3'b000) && (bus.Hsize <= 3'd2);

    always_comb begin
        w_sel = 3'b000;
        case (bus.Haddr[ADDR_W-1 -: 6])
            6'b100000: w_sel = 3'b001;
            6'b100001: w_sel = 3'b010;
            6'b100010: w_sel = 3'b100;
            default:   w_sel = 3'b000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hreadyout = 1'b1;
        w_hresp     = 2'b00;
        case (r_state)
            S_OKAY: begin
                w_hreadyout = bus.apb_ready;
                if (w_accept && !w_ok)
                    w_state_nxt = S_ERR1;
            end
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 2'b01;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                w_hreadyout = 1'b1;
                w_hresp     = 2'b01;
                w_state_nxt = S_OKAY;
            end
            default: w_state_nxt = S_OKAY;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset)
            r_state <= S_OKAY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_valid   <= 1'b0;
            r_dphase  <= 1'b0;
            r_haddr1  <= '0;
            r_haddr2  <= '0;
            r_hwdata1 <= '0;
            r_hwdata2 <= '0;
            r_hwrite1 <= 1'b0;
            r_hwrite2 <= 1'b0;
            r_sel     <= 3'b000;
        end else if (w_hreadyout) begin
            r_valid  <= w_accept && w_ok;
            r_dphase <= w_accept && w_ok && bus.Hwrite;
            if (w_accept && w_ok) begin
                r_haddr1  <= bus.Haddr;
                r_hwrite1 <= bus.Hwrite;
                r_sel     <= w_sel;
            end
            if (r_dphase)
                r_hwdata1 <= bus.Hwdata;
            r_haddr2  <= r_haddr1;
            r_hwrite2 <= r_hwrite1;
            r_hwdata2 <= r_hwdata1;
        end
    end

    always_comb begin
        w_beats_m1 = 5'd0;
        case (bus.Hburst)
            3'd2, 3'd3: w_beats_m1 = 5'd3;
            3'd4, 3'd5: w_beats_m1 = 5'd7;
            3'd6, 3'd7: w_beats_m1 = 5'd15;
            default:    w_beats_m1 = 5'd0;
        endcase
    end

    assign w_len     = {1'b0, w_beats_m1} + 6'd1;
    assign w_incr    = ADDR_W'(1) << bus.Hsize;
    assign w_mask    = (ADDR_W'(w_len) << bus.Hsize) - ADDR_W'(1);
    assign w_is_wrap = !bus.Hburst[0] && (bus.Hburst != 3'd0);
    assign w_seq_err = !r_in_burst || (bus.Haddr != r_exp_addr) ||
                       (r_fixed && (r_beats_left == 5'd0));

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_in_burst   <= 1'b0;
            r_fixed      <= 1'b0;
            r_wrap       <= 1'b0;
            r_beats_left <= '0;
            r_exp_addr   <= '0;
            r_incr       <= '0;
            r_mask       <= '0;
            r_burst_err  <= 1'b0;
        end else if (w_xfer) begin
            case (bus.Htrans)
                TR_NONSEQ: begin
                    r_in_burst   <= 1'b1;
                    r_fixed      <= (bus.Hburst != 3'd1);
                    r_wrap       <= w_is_wrap;
                    r_beats_left <= w_beats_m1;
                    r_incr       <= w_incr;
                    r_mask       <= w_mask;
                    r_exp_addr   <= f_next(bus.Haddr, w_incr, w_mask, w_is_wrap);
                end
                TR_SEQ: begin
                    if (w_seq_err) begin
                        r_burst_err <= 1'b1;
                    end else begin
                        if (r_fixed)
                            r_beats_left <= r_beats_left - 5'd1;
                        r_exp_addr <= f_next(r_exp_addr, r_incr, r_mask, r_wrap);
                    end
                end
                TR_IDLE: r_in_burst <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.valid      = r_valid;
    assign bus.Haddr1     = r_haddr1;
    assign bus.Haddr2     = r_haddr2;
    assign bus.Hwdata1    = r_hwdata1;
    assign bus.Hwdata2    = r_hwdata2;
    assign bus.Hwritereg  = r_hwrite1;
    assign bus.Hwritereg1 = r_hwrite2;
    assign bus.tempselx   = r_sel;
    assign bus.Hreadyout  = w_hreadyout;
    assign bus.Hresp      = w_hresp;
    assign bus.burst_err  = r_burst_err;
endmodule
